// File: rtl/bcd_to_bin.sv
// Purpose : packed-BCD to binary converter using reverse double-dabble
//           (shift right, subtract 3 from every BCD nibble >= 8).
// Latency : done pulses 2+8*NDIGITS edges after start is sampled, or 2 edges for invalid input.
// Backpressure: none; start is ignored while busy and not queued.
// Ports   : clk, rst_n (async active-low)
//           start  - request; sampled only when idle
//           bcdin  - packed BCD operand, MS digit in top nibble; captured with start
//           binout - binary result; holds the last valid result
//           busy   - high while a conversion is in flight
//           done   - one-cycle completion pulse (valid or error)
//           err    - updated with done; high if any input nibble was > 9
module bcd_to_bin #(
   parameter int NDIGITS = 4,
   parameter int BIN_W   = 14
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [4*NDIGITS-1:0]   bcdin,
   output logic [BIN_W-1:0]       binout,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   localparam int W  = 4 * NDIGITS;
   localparam int CW = $clog2(W + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_CORRECT,
      S_FIN
   } state_t;

   state_t            state_q, state_d;
   logic [2*W-1:0]    sr_q, sr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              bad_q, bad_d;
   logic              err_q, err_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [BIN_W-1:0]  bin_q, bin_d;

   // Per-nibble view of the BCD half of the shift register.
   logic              nib_bad;
   logic [W-1:0]      bcd_corr;

   always_comb begin
      nib_bad  = 1'b0;
      bcd_corr = sr_q[2*W-1:W];
      for (int i = 0; i < NDIGITS; i++) begin
         if (sr_q[W + 4*i +: 4] > 4'd9) begin
            nib_bad = 1'b1;
         end
         // After a right shift a nibble >= 8 carried a "ten" across the
         // boundary as 16/2 = 8; subtracting 3 turns that into 5 (= 10/2).
         if (sr_q[W + 4*i +: 4] >= 4'd8) begin
            bcd_corr[4*i +: 4] = sr_q[W + 4*i +: 4] - 4'd3;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      bad_d   = bad_q;
      err_d   = err_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      bin_d   = bin_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               sr_d    = {bcdin, {W{1'b0}}};
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            // The error flag is kept internally until the done pulse so the
            // err output stays stable between completions.
            bad_d   = nib_bad;
            state_d = nib_bad ? S_FIN : S_SHIFT;
         end
         S_SHIFT: begin
            sr_d    = {1'b0, sr_q[2*W-1:1]};
            cnt_d   = cnt_q + CW'(1);
            state_d = S_CORRECT;
         end
         S_CORRECT: begin
            if (cnt_q == CW'(W)) begin
               state_d = S_FIN;
            end else begin
               sr_d    = {bcd_corr, sr_q[W-1:0]};
               state_d = S_SHIFT;
            end
         end
         S_FIN: begin
            if (!bad_q) begin
               // Bits of acc above BIN_W are zero for any valid operand.
               bin_d = sr_q[BIN_W-1:0];
            end
            err_d   = bad_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         bad_q   <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         bin_q   <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         bad_q   <= bad_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         bin_q   <= bin_d;
      end
   end

   assign binout = bin_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign err    = err_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
module tb_bcd_to_bin;

   localparam int LAT_OK  = 34;  // edges from the start edge to the done edge
   localparam int LAT_ERR = 2;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] bcdin;
   logic [13:0] binout;
   logic        busy;
   logic        done;
   logic        err;

   int n_checks = 0;
   int n_pass   = 0;
   bit checking = 0;

   bcd_to_bin #(.NDIGITS(4), .BIN_W(14)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .bcdin  (bcdin),
      .binout (binout),
      .busy   (busy),
      .done   (done),
      .err    (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)", name, act, act, exp, exp);
   endtask

   function automatic bit bcd_ok(input logic [15:0] x);
      bcd_ok = 1'b1;
      for (int i = 0; i < 4; i++)
         if (x[4*i +: 4] > 4'd9) bcd_ok = 1'b0;
   endfunction

   function automatic int bcd_val(input logic [15:0] x);
      bcd_val = 0;
      for (int i = 3; i >= 0; i--)
         bcd_val = bcd_val * 10 + int'(x[4*i +: 4]);
   endfunction

   // Transaction-level reference: a conversion is a countdown from the
   // accepted start to the done edge; start is ignored while counting.
   logic        m_busy, m_done, m_err;
   logic [13:0] m_bin;
   int          m_left;
   bit          p_err;
   int          p_val;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 0; m_done = 0; m_err = 0; m_bin = '0; m_left = 0;
      end else begin
         m_done = 0;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_done = 1;
               m_busy = 0;
               m_err  = p_err;
               if (!p_err) m_bin = 14'(p_val);
            end
         end else if (start) begin
            p_err  = !bcd_ok(bcdin);
            p_val  = bcd_val(bcdin);
            m_busy = 1;
            m_left = p_err ? LAT_ERR : LAT_OK;
         end
      end
   end

   always @(negedge clk) begin
      if (checking)
         check("cycle {busy,done,err,binout}", int'({busy, done, err, binout}),
               int'({m_busy, m_done, m_err, m_bin}));
   end

   task automatic wait_done(output bit seen, output int lat);
      seen = 0;
      lat  = -1;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1;
            lat  = i;
         end
      end
   endtask

   // Returns at the negedge inside the done cycle.
   task automatic convert(input logic [15:0] v, input int exp_bin, input bit exp_err,
                          input int exp_lat, input string tag);
      bit seen;
      int lat;
      @(negedge clk);
      bcdin = v;
      start = 1;
      @(negedge clk);
      start = 0;
      bcdin = 16'($urandom);
      check({tag, " busy"}, int'(busy), 1);
      wait_done(seen, lat);
      check({tag, " done seen"}, int'(seen), 1);
      check({tag, " latency"}, lat, exp_lat);
      check({tag, " binout"}, int'(binout), exp_bin);
      check({tag, " err"}, int'(err), int'(exp_err));
   endtask

   initial begin
      bit          seen;
      int          lat;
      int          ndone;
      int          r;
      logic [15:0] b;

      rst_n = 0;
      start = 0;
      bcdin = '0;
      repeat (3) @(negedge clk);
      check("reset binout", int'(binout), 0);
      check("reset busy", int'(busy), 0);
      check("reset done", int'(done), 0);
      check("reset err", int'(err), 0);
      #1 rst_n = 1;
      checking = 1;

      // Pin the model's decoding against hand values.
      check("model 0x0815", bcd_val(16'h0815), 815);
      check("model 0x12A4 ok", int'(bcd_ok(16'h12A4)), 0);

      convert(16'h1234, 1234, 0, LAT_OK - 1, "1234");
      convert(16'h9999, 9999, 0, LAT_OK - 1, "9999");
      convert(16'h0000, 0, 0, LAT_OK - 1, "0000");
      convert(16'h1234, 1234, 0, LAT_OK - 1, "1234b");
      convert(16'h12A4, 1234, 1, LAT_ERR - 1, "12A4 err");
      convert(16'hF000, 1234, 1, LAT_ERR - 1, "F000 err");
      convert(16'h0007, 7, 0, LAT_OK - 1, "0007 clears err");

      // start mid-conversion is ignored, then back-to-back start on done.
      @(negedge clk);
      bcdin = 16'h0042;
      start = 1;
      @(negedge clk);
      start = 0;
      repeat (4) @(negedge clk);
      bcdin = 16'h0077;
      start = 1;
      @(negedge clk);
      start = 0;
      wait_done(seen, lat);
      check("0042 done seen", int'(seen), 1);
      check("0042 binout", int'(binout), 42);
      bcdin = 16'h0321;
      start = 1;
      @(negedge clk);
      start = 0;
      check("b2b busy", int'(busy), 1);
      wait_done(seen, lat);
      check("b2b done seen", int'(seen), 1);
      check("b2b latency", lat, LAT_OK - 1);
      check("b2b binout", int'(binout), 321);

      // Reset in the middle of a conversion discards it.
      @(negedge clk);
      bcdin = 16'h5678;
      start = 1;
      @(negedge clk);
      start = 0;
      repeat (18) @(negedge clk);
      #1 rst_n = 0;
      @(negedge clk);
      check("midreset busy", int'(busy), 0);
      check("midreset binout", int'(binout), 0);
      #1 rst_n = 1;
      ndone = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("midreset no done", ndone, 0);
      convert(16'h0005, 5, 0, LAT_OK - 1, "0005");

      // Valid operands, expectation taken from the integer that built them.
      for (int n = 0; n < 1000; n++) begin
         r = $urandom_range(9999);
         b = {4'(r / 1000), 4'((r / 100) % 10), 4'((r / 10) % 10), 4'(r % 10)};
         convert(b, r, 0, LAT_OK - 1, "rand");
      end

      checking = 0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
